// File: rtl/abs_peak_detect_pkg.sv
// Shared constants and FSM encoding for the windowed magnitude peak detector.
package abs_peak_detect_pkg;

  localparam int MAG_DW      = 29;
  localparam int WIN_LEN_DEF = 1024;
  localparam int IDX_W_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/abs_peak_detect_cmp.sv
// Registered compare-and-select of {value, index} pairs; b wins only on strict
// greater-than (or when forced), so ties keep the earlier index held in a.
module abs_peak_cmp
  import abs_peak_detect_pkg::*;
#(
  parameter int DW    = MAG_DW,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             force_b,
  input  logic [DW-1:0]    a_val,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [DW-1:0]    b_val,
  input  logic [IDX_W-1:0] b_idx,
  output logic [DW-1:0]    q_val,
  output logic [IDX_W-1:0] q_idx
);

  logic sel_b;

  assign sel_b = force_b | (b_val > a_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_val <= '0;
      q_idx <= '0;
    end else if (clr) begin
      q_val <= '0;
      q_idx <= '0;
    end else if (en) begin
      q_val <= sel_b ? b_val : a_val;
      q_idx <= sel_b ? b_idx : a_idx;
    end
  end

endmodule

// File: rtl/abs_peak_detect.sv
// Windowed peak search over a valid-qualified magnitude stream with threshold detect.
// Optional ABS_PEAK_DETECT_MEAN_EN adds a window mean output and a peak-to-mean detect gate.
module abs_peak_detect
  import abs_peak_detect_pkg::*;
#(
  parameter int DW      = MAG_DW,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Cont,
  input  logic [DW-1:0]    Thresh,
  input  logic             Nd,
  input  logic [DW-1:0]    Din,
  output logic             Busy,
  output logic             Peak_Rdy,
  output logic [DW-1:0]    Peak_Val,
  output logic [IDX_W-1:0] Peak_Idx,
`ifdef ABS_PEAK_DETECT_MEAN_EN
  output logic [DW-1:0]    Win_Mean,
`endif
  output logic             Det
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt_p0;
  logic [DW-1:0]    thresh_q;
  logic             cont_q;
  logic             accept, last, fin;
  logic [DW-1:0]    max_val_p0, res_val_p1;
  logic [IDX_W-1:0] max_idx_p0, res_idx_p1;
  logic             vld_p1, vld_p2;
  logic             det_p1;

  assign accept = (state == SEARCH) & Nd & ~Start;
  assign last   = (cnt_p0 == IDX_W'(WIN_LEN - 1));
  assign fin    = accept & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Start)
      state_nxt = SEARCH;
    else if ((state == SEARCH) && fin && !cont_q)
      state_nxt = HOLD;
  end

  always_comb begin
    Busy = (state == SEARCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      cont_q   <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      if (Start) begin
        thresh_q <= Thresh;
        cont_q   <= Cont;
      end
      if (Start || fin) cnt_p0 <= '0;
      else if (accept)  cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // p0: running max of the window; sample 0 always loads over the cleared state
  abs_peak_cmp #(.DW(DW), .IDX_W(IDX_W)) u_run_max (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (accept),
    .clr     (Start | fin),
    .force_b (cnt_p0 == '0),
    .a_val   (max_val_p0),
    .a_idx   (max_idx_p0),
    .b_val   (Din),
    .b_idx   (cnt_p0),
    .q_val   (max_val_p0),
    .q_idx   (max_idx_p0)
  );

  // p1: final sample merged with the running max into the result register
  abs_peak_cmp #(.DW(DW), .IDX_W(IDX_W)) u_merge (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (fin),
    .clr     (1'b0),
    .force_b (1'b0),
    .a_val   (max_val_p0),
    .a_idx   (max_idx_p0),
    .b_val   (Din),
    .b_idx   (cnt_p0),
    .q_val   (res_val_p1),
    .q_idx   (res_idx_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= fin;
  end

`ifdef ABS_PEAK_DETECT_MEAN_EN
  logic [DW+IDX_W-1:0] sum_p0, res_sum_p1;
  logic [DW-1:0]       mean_p1;

  function automatic logic [DW-1:0] win_mean(input logic [DW+IDX_W-1:0] s);
    return s[DW+IDX_W-1:IDX_W];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p0     <= '0;
      res_sum_p1 <= '0;
    end else begin
      if (fin) res_sum_p1 <= sum_p0 + {{IDX_W{1'b0}}, Din};
      if (Start || fin) sum_p0 <= '0;
      else if (accept)  sum_p0 <= sum_p0 + {{IDX_W{1'b0}}, Din};
    end
  end

  assign mean_p1 = win_mean(res_sum_p1);
  // Peak must reach twice the mean; both sides widened so 2*mean cannot wrap
  assign det_p1  = (res_val_p1 >= thresh_q) &&
                   ({1'b0, res_val_p1} >= {mean_p1, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      Win_Mean <= '0;
    else if (vld_p1) Win_Mean <= mean_p1;
  end
`else
  assign det_p1 = (res_val_p1 >= thresh_q);
`endif

  // p2: output register, holds until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      Peak_Val <= '0;
      Peak_Idx <= '0;
      Det      <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        Peak_Val <= res_val_p1;
        Peak_Idx <= res_idx_p1;
        Det      <= det_p1;
      end
    end
  end

  assign Peak_Rdy = vld_p2;

endmodule

// File: tb/tb_abs_peak_detect.sv
// Scoreboard bench for abs_peak_detect with an 8-sample window.
module tb_abs_peak_detect;
  localparam int DW = 29;
  localparam int WL = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n, Start, Cont, Nd;
  logic [DW-1:0] Thresh, Din;
  logic          Busy, Peak_Rdy, Det;
  logic [DW-1:0] Peak_Val;
  logic [IW-1:0] Peak_Idx;
`ifdef ABS_PEAK_DETECT_MEAN_EN
  logic [DW-1:0] Win_Mean;
`endif

  abs_peak_detect #(.DW(DW), .WIN_LEN(WL), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Cont     (Cont),
    .Thresh   (Thresh),
    .Nd       (Nd),
    .Din      (Din),
    .Busy     (Busy),
    .Peak_Rdy (Peak_Rdy),
    .Peak_Val (Peak_Val),
    .Peak_Idx (Peak_Idx),
`ifdef ABS_PEAK_DETECT_MEAN_EN
    .Win_Mean (Win_Mean),
`endif
    .Det      (Det)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    logic [IW-1:0] idx;
    logic          det;
    logic [DW-1:0] mean;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] wsum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    Nd = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start(input logic [DW-1:0] th, input logic c);
    Start = 1'b1; Thresh = th; Cont = c; Nd = 1'b0;
    tick();
    Start = 1'b0;
    wsum = '0;
  endtask

  task automatic sample(input logic [DW-1:0] d);
    Nd = 1'b1; Din = d;
    wsum = wsum + 32'(d);
    tick();
    Nd = 1'b0;
  endtask

  task automatic sample_last(input logic [DW-1:0] d, input logic [DW-1:0] v,
                             input logic [IW-1:0] i, input logic dt);
    exp_t e;
    Nd = 1'b1; Din = d;
    wsum = wsum + 32'(d);
    e.val = v; e.idx = i; e.det = dt;
    e.mean = DW'(wsum >> IW);
    e.cyc = cyc + 2;
    sb.push_back(e);
    wsum = '0;
    tick();
    Nd = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (Peak_Rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got Peak_Rdy=1 val=%0h expected no strobe (cycle %0d)", Peak_Val, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("peak_val", 64'(Peak_Val), 64'(e.val));
        chk("peak_idx", 64'(Peak_Idx), 64'(e.idx));
        chk("det",      64'(Det),      64'(e.det));
        chk("strobe_cycle", 64'(cyc),  64'(e.cyc));
`ifdef ABS_PEAK_DETECT_MEAN_EN
        chk("win_mean", 64'(Win_Mean), 64'(e.mean));
`endif
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; Start = 1'b0; Cont = 1'b0; Nd = 1'b0; Thresh = '0; Din = '0; wsum = '0;
    tick(); tick();
    chk("rst_busy",     64'(Busy),     64'd0);
    chk("rst_peak_rdy", 64'(Peak_Rdy), 64'd0);
    chk("rst_peak_val", 64'(Peak_Val), 64'd0);
    chk("rst_peak_idx", 64'(Peak_Idx), 64'd0);
    chk("rst_det",      64'(Det),      64'd0);
    rst_n = 1'b1;
    tick();

    // Single window, tie at 300 keeps index 2
    start(100, 1'b0);
    chk("busy_search", 64'(Busy), 64'd1);
    sample(5); sample(9); sample(300); sample(7); sample(300); sample(2); sample(1);
    sample_last(0, 300, 2, 1'b1);
    chk("busy_hold", 64'(Busy), 64'd0);
    sample(400); sample(500); sample(600);
    idle(4);

    // Below threshold, alternate-cycle gaps
    start(1000, 1'b0);
    sample(5); idle(1); sample(9); idle(1); sample(300); idle(1); sample(7); idle(1);
    sample(300); idle(1); sample(2); idle(1); sample(1); idle(1);
    sample_last(0, 300, 2, 1'b0);
    idle(4);

    // Continuous mode, two back-to-back windows
    start(60, 1'b1);
    sample(1); sample(2); sample(3); sample(50); sample(4); sample(5); sample(6);
    sample_last(7, 50, 3, 1'b0);
    sample(10); sample(11); sample(12); sample(13); sample(14); sample(15); sample(77);
    sample_last(16, 77, 6, 1'b1);
    idle(4);
    chk("busy_cont", 64'(Busy), 64'd1);

    // Abort at sample 5 with a coincident (discarded) Nd, then all-ones peak
    start(0, 1'b0);
    sample(1000); sample(2000); sample(3000); sample(4000); sample(5000);
    Start = 1'b1; Thresh = '0; Cont = 1'b0; Nd = 1'b1; Din = 29'h1FFFFFFE;
    tick();
    Start = 1'b0; Nd = 1'b0; wsum = '0;
    sample(1); sample(2); sample(3); sample(4); sample(5); sample(6); sample(7);
    sample_last(29'h1FFFFFFF, 29'h1FFFFFFF, 7, 1'b1);
    idle(4);
    chk("busy_after_abort", 64'(Busy), 64'd0);

    // Reset mid-window at sample 6
    start(0, 1'b0);
    sample(40); sample(41); sample(42); sample(43); sample(44); sample(45);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",     64'(Busy),     64'd0);
    chk("mid_rst_peak_val", 64'(Peak_Val), 64'd0);
    chk("mid_rst_peak_idx", 64'(Peak_Idx), 64'd0);
    chk("mid_rst_det",      64'(Det),      64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    sample(900); sample(901); sample(902); sample(903);
    idle(3);
    chk("idle_after_rst", 64'(Busy), 64'd0);

    // Reset while the result is in flight kills the strobe
    start(5, 1'b0);
    sample(1); sample(2); sample(3); sample(4); sample(5); sample(6); sample(7); sample(8);
    rst_n = 1'b0;
    #1;
    chk("kill_peak_rdy", 64'(Peak_Rdy), 64'd0);
    tick();
    rst_n = 1'b1;
    idle(4);

`ifdef ABS_PEAK_DETECT_MEAN_EN
    start(0, 1'b0);
    sample(10); sample(10); sample(30); sample(10); sample(10); sample(10); sample(10);
    sample_last(10, 30, 2, 1'b1);
    idle(4);
    start(0, 1'b0);
    sample(10); sample(20); sample(10); sample(10); sample(10); sample(10); sample(10);
    sample_last(10, 20, 1, 1'b0);
    idle(4);
`endif

    idle(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
